vector_sequencer: RTL and testbench
===================================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 100: clock cycles each vector is held on vec; legal range 1..255.
REQ-002 Parameter NUM_VEC, default 8: table depth; fixed at 8 (3-bit index).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a run.
REQ-006 wr_en  input  1  table write strobe.
REQ-007 wr_addr  input  3  table entry index.
REQ-008 wr_vec  input  4  stimulus {a,b,c,d} to store.
REQ-009 wr_exp  input  1  expected DUT output to store.
REQ-010 dut_out  input  1  combinational response of the downstream 4-input UDP stage.
REQ-011 vec  output  4  stimulus {a,b,c,d}, registered.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  one-cycle pulse at run end.
REQ-014 err_count  output  4  mismatches in the last run, saturating at 15.
REQ-015 first_err  output  3  index of the first mismatching entry; valid when err_count != 0.
REQ-016 pass  output  1  high after a completed run with err_count == 0; cleared by start.

Function
REQ-017 FSM states: IDLE, APPLY, SAMPLE, FINISH; encoding is free.
REQ-018 IDLE: vec = 4'b0000, busy = 0; start -> APPLY, idx = 0, err_count = 0, first_err = 0, pass = 0.
REQ-019 APPLY entry: vec <= table[idx].vec in the same edge; hold counter loads HOLD_CYCLES-1.
REQ-020 APPLY: counter decrements each cycle; on count 0 -> SAMPLE; vec stays stable for exactly HOLD_CYCLES cycles.
REQ-021 SAMPLE (one cycle): compare dut_out to table[idx].exp; on mismatch, increment err_count (saturating); if this is the first mismatch, first_err <= idx.
REQ-022 SAMPLE: if idx == NUM_VEC-1 -> FINISH, else idx+1 -> APPLY.
REQ-023 FINISH (one cycle): done = 1; pass <= (err_count == 0); vec <= 4'b0000; -> IDLE.
REQ-024 busy = 1 in APPLY, SAMPLE and FINISH.
REQ-025 start while busy is ignored.
REQ-026 wr_en while busy is ignored; in IDLE, the write takes effect on the next edge.
REQ-027 start and wr_en in the same IDLE cycle: the write commits first and the run uses the new entry.
REQ-028 HOLD_CYCLES = 1: APPLY lasts one cycle.
REQ-029 A run lasts NUM_VEC*(HOLD_CYCLES+1)+1 cycles from start to the done pulse, inclusive of FINISH.
REQ-030 Reference response for table content: exp = ~c | ~d | (a & ~b).

Reset
REQ-031 rst forces IDLE, idx = 0, vec = 0, busy = 0, done = 0, err_count = 0, first_err = 0, pass = 0, regardless of state.
REQ-032 rst reloads the default table, entries 0..7 as vec/exp: 0000/1, 0001/1, 0011/0, 0110/1, 1001/1, 1111/0, 1101/1, 1000/1.
REQ-033 rst asserted mid-run aborts the run with no done pulse; the first cycle after rst deasserts is IDLE.

Structure
REQ-034 A shared include file SHALL hold the state encodings, the default table constants and the 4-bit vector width.
REQ-035 A sub-module hold_counter SHALL provide a loadable down-counter with a zero flag.
REQ-036 The table SHALL be flops (8 x 5 bits), not inferred RAM.

Verification
REQ-037 Reset, then start with the udp stage attached -> done after 8*101+1 = 809 cycles, err_count = 0, pass = 1.
REQ-038 Write entry 2 with exp = 1, then start -> err_count = 1, first_err = 2, pass = 0.
REQ-039 Force dut_out = 0 and start -> err_count = 6, first_err = 0.
REQ-040 Assert start again 50 cycles into a run -> no restart; done occurs once, at the original time.
REQ-041 Assert rst at cycle 300 of a run -> busy = 0 and vec = 0 next cycle, no done, table back to defaults.
REQ-042 Run with HOLD_CYCLES = 1 -> each vec is held 1 cycle and done arrives 17 cycles after start.

Source files
------------

// File: rtl/vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer: widths, state encoding, table entry
// layout and the reset-time stimulus table.
package vector_sequencer_pkg;

  localparam int VEC_W = 4;
  localparam int IDX_W = 3;
  localparam int N_ENT = 8;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_FINISH} state_t;

  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic             exp;
  } entry_t;

  // Expected values follow the reference response ~c | ~d | (a & ~b) on {a,b,c,d}
  function automatic entry_t def_entry(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    def_entry = '{vec: 4'b0000, exp: 1'b1};
      3'd1:    def_entry = '{vec: 4'b0001, exp: 1'b1};
      3'd2:    def_entry = '{vec: 4'b0011, exp: 1'b0};
      3'd3:    def_entry = '{vec: 4'b0110, exp: 1'b1};
      3'd4:    def_entry = '{vec: 4'b1001, exp: 1'b1};
      3'd5:    def_entry = '{vec: 4'b1111, exp: 1'b0};
      3'd6:    def_entry = '{vec: 4'b1101, exp: 1'b1};
      default: def_entry = '{vec: 4'b1000, exp: 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/vector_sequencer_hold_counter.sv
// Loadable down-counter with a zero flag; paces how long each vector stays on the bus.
module hold_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Steps through an 8-entry stimulus table, holds each vector for HOLD_CYCLES,
// then samples the downstream response and tallies mismatches.
module vector_sequencer
  import vector_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 100,
  parameter int NUM_VEC     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [VEC_W-1:0] wr_vec,
  input  logic             wr_exp,
  input  logic             dut_out,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic [3:0]       err_count,
  output logic [IDX_W-1:0] first_err,
  output logic             pass
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VEC - 1);
  localparam logic [7:0]       HOLD_LD = 8'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  entry_t           tbl [N_ENT];
  logic [IDX_W-1:0] idx;
  logic             wr_ok, hold_zero, cnt_load;
  logic [VEC_W-1:0] first_vec;

  assign wr_ok = wr_en && (state == S_IDLE);
  // A write to entry 0 in the start cycle must reach the bus on that same edge
  assign first_vec = (wr_ok && wr_addr == '0) ? wr_vec : tbl[0].vec;
  assign cnt_load  = (state == S_IDLE && start) || (state == S_SAMPLE && idx != LAST);

  hold_counter #(.W(8)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (HOLD_LD),
    .dec      (state == S_APPLY),
    .zero     (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_APPLY;
      S_APPLY:  if (hold_zero) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (idx == LAST) ? S_FINISH : S_APPLY;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENT; i++) tbl[i] <= def_entry(IDX_W'(i));
    end else if (wr_ok) begin
      tbl[wr_addr] <= '{vec: wr_vec, exp: wr_exp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      idx       <= '0;
      err_count <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          vec       <= first_vec;
          idx       <= '0;
          err_count <= '0;
          first_err <= '0;
          pass      <= 1'b0;
        end
        S_SAMPLE: begin
          if (dut_out != tbl[idx].exp) begin
            if (err_count != 4'hf) err_count <= err_count + 4'd1;
            if (err_count == '0)   first_err <= idx;
          end
          if (idx != LAST) begin
            idx <= idx + 1'b1;
            vec <= tbl[idx + 1'b1].vec;
          end
        end
        S_FINISH: begin
          pass <= (err_count == '0);
          vec  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench: default run, table edits, forced response, restart/reset abuse
// and a fast HOLD_CYCLES=1 instance.
module tb_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, wr_en, wr_exp, force0;
  logic [2:0] wr_addr;
  logic [3:0] wr_vec;
  logic       dut_out;
  logic [3:0] vec, err_count;
  logic       busy, done, pass;
  logic [2:0] first_err;

  logic       start1, dut_out1, busy1, done1, pass1;
  logic [3:0] vec1, err_count1;
  logic [2:0] first_err1;

  int total = 0;
  int bad   = 0;

  logic [3:0] def_vec [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110,
                              4'b1001, 4'b1111, 4'b1101, 4'b1000};

  always #5 clk = ~clk;

  // Reference 4-input stage on {a,b,c,d}
  assign dut_out  = force0 ? 1'b0 : (~vec[1] | ~vec[0] | (vec[3] & ~vec[2]));
  assign dut_out1 = ~vec1[1] | ~vec1[0] | (vec1[3] & ~vec1[2]);

  vector_sequencer #(.HOLD_CYCLES(100), .NUM_VEC(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_vec(wr_vec), .wr_exp(wr_exp), .dut_out(dut_out), .vec(vec), .busy(busy),
    .done(done), .err_count(err_count), .first_err(first_err), .pass(pass)
  );

  vector_sequencer #(.HOLD_CYCLES(1), .NUM_VEC(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .wr_en(1'b0), .wr_addr(3'd0),
    .wr_vec(4'd0), .wr_exp(1'b0), .dut_out(dut_out1), .vec(vec1), .busy(busy1),
    .done(done1), .err_count(err_count1), .first_err(first_err1), .pass(pass1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Pulses start, then runs 820 cycles; optionally re-pulses start (plus a write) mid-run.
  task automatic run_main(input int restart_at, output int first_done, output int ndone,
                          output int vbad);
    first_done = 0; ndone = 0; vbad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 820; n++) begin
      if (n <= 808 && vec !== def_vec[(n - 1) / 101]) vbad++;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = n;
      end
      if (n == restart_at) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_vec = 4'b0011; wr_exp = 1'b1;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (vec !== 4'b0000) begin bad++; $display("FAIL reset_vec got=%b want=0000", vec); end
    total++; if (err_count !== 4'd0 || first_err !== 3'd0 || pass !== 1'b0) begin
      bad++; $display("FAIL reset_status got err=%0d first=%0d pass=%b want 0/0/0",
                      err_count, first_err, pass);
    end
  endtask

  task automatic test_default_run();
    int fd, nd, vb;
    run_main(0, fd, nd, vb);
    total++; if (fd !== 809) begin bad++; $display("FAIL default_latency got=%0d want=809", fd); end
    total++; if (nd !== 1) begin bad++; $display("FAIL default_done_count got=%0d want=1", nd); end
    total++; if (vb !== 0) begin bad++; $display("FAIL default_vec_seq bad_cycles=%0d want=0", vb); end
    total++; if (err_count !== 4'd0 || pass !== 1'b1) begin
      bad++; $display("FAIL default_result got err=%0d pass=%b want 0/1", err_count, pass);
    end
    total++; if (busy !== 1'b0 || vec !== 4'b0000) begin
      bad++; $display("FAIL default_idle got busy=%b vec=%b want 0/0000", busy, vec);
    end
  endtask

  task automatic test_write_exp();
    int fd, nd, vb;
    wr_en = 1'b1; wr_addr = 3'd2; wr_vec = 4'b0011; wr_exp = 1'b1;
    tick();
    wr_en = 1'b0;
    run_main(0, fd, nd, vb);
    total++; if (err_count !== 4'd1 || first_err !== 3'd2 || pass !== 1'b0) begin
      bad++; $display("FAIL write_exp got err=%0d first=%0d pass=%b want 1/2/0",
                      err_count, first_err, pass);
    end
  endtask

  task automatic test_write_with_start();
    int n;
    do_reset();
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_vec = 4'b0011; wr_exp = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    total++; if (vec !== 4'b0011) begin bad++; $display("FAIL same_cycle_vec got=%b want=0011", vec); end
    n = 1;
    while (!done && n < 900) begin tick(); n++; end
    total++; if (n !== 809) begin bad++; $display("FAIL same_cycle_latency got=%0d want=809", n); end
    tick();
    total++; if (err_count !== 4'd1 || first_err !== 3'd0 || pass !== 1'b0) begin
      bad++; $display("FAIL same_cycle_result got err=%0d first=%0d pass=%b want 1/0/0",
                      err_count, first_err, pass);
    end
  endtask

  task automatic test_force_zero();
    int fd, nd, vb;
    do_reset();
    force0 = 1'b1;
    run_main(0, fd, nd, vb);
    force0 = 1'b0;
    total++; if (err_count !== 4'd6 || first_err !== 3'd0 || pass !== 1'b0) begin
      bad++; $display("FAIL force_zero got err=%0d first=%0d pass=%b want 6/0/0",
                      err_count, first_err, pass);
    end
  endtask

  task automatic test_start_while_busy();
    int fd, nd, vb;
    run_main(50, fd, nd, vb);
    total++; if (fd !== 809 || nd !== 1) begin
      bad++; $display("FAIL restart_ignored got done_at=%0d count=%0d want 809/1", fd, nd);
    end
    total++; if (err_count !== 4'd0 || pass !== 1'b1) begin
      bad++; $display("FAIL busy_write_ignored got err=%0d pass=%b want 0/1", err_count, pass);
    end
  endtask

  task automatic test_reset_mid_run();
    int fd, nd, vb, seen;
    wr_en = 1'b1; wr_addr = 3'd5; wr_vec = 4'b1111; wr_exp = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 300; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || vec !== 4'b0000 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset got busy=%b vec=%b done=%b want 0/0000/0", busy, vec, done);
    end
    seen = 0;
    for (int n = 0; n < 820; n++) begin
      if (done) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_no_done got=%0d want=0", seen); end
    run_main(0, fd, nd, vb);
    total++; if (err_count !== 4'd0 || pass !== 1'b1 || vb !== 0) begin
      bad++; $display("FAIL mid_reset_table got err=%0d pass=%b vbad=%0d want 0/1/0",
                      err_count, pass, vb);
    end
  endtask

  task automatic test_hold1();
    int n, vb;
    vb = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 100) begin
      if (n <= 16 && vec1 !== def_vec[(n - 1) / 2]) vb++;
      tick();
      n++;
    end
    total++; if (n !== 17) begin bad++; $display("FAIL hold1_latency got=%0d want=17", n); end
    total++; if (vb !== 0) begin bad++; $display("FAIL hold1_vec_seq bad_cycles=%0d want=0", vb); end
    tick();
    total++; if (pass1 !== 1'b1 || err_count1 !== 4'd0) begin
      bad++; $display("FAIL hold1_result got err=%0d pass=%b want 0/1", err_count1, pass1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_vec = '0; wr_exp = 1'b0;
    force0 = 1'b0; start1 = 1'b0;
    test_reset();
    test_default_run();
    test_write_exp();
    test_write_with_start();
    test_force_zero();
    test_start_while_busy();
    test_reset_mid_run();
    test_hold1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
